// File: rtl/mat_pkg.sv
// Shared types for the matrix RAM read streamer: FSM states, buffer depth
// and the per-element tag carried alongside each read.
package mat_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_e;

  localparam int RD_BUF_DEPTH = 2;

  typedef struct packed {
    logic eor;
    logic last;
  } rd_tag_t;

endpackage

// File: rtl/mat_rd_buf.sv
// Small FIFO holding returned RAM words with their row/matrix end tags.
// A pop in the same cycle frees a slot, so push is accepted even when full.
module mat_rd_buf
  import mat_pkg::*;
#(
  parameter int DATA = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic [DATA-1:0] pushData_i,
  input  rd_tag_t         pushTag_i,
  input  logic            pop_i,
  output logic [1:0]      count_o,
  output logic [DATA-1:0] headData_o,
  output rd_tag_t         headTag_o
);

  localparam int PW = (RD_BUF_DEPTH > 1) ? $clog2(RD_BUF_DEPTH) : 1;

  logic [DATA-1:0] data_q [RD_BUF_DEPTH];
  rd_tag_t         tag_q  [RD_BUF_DEPTH];
  logic [PW-1:0]   rdPtr_q, wrPtr_q;
  logic [1:0]      count_q;
  logic            doPop, doPush;

  assign doPop  = pop_i && (count_q != 2'd0);
  assign doPush = push_i && ((count_q != 2'(RD_BUF_DEPTH)) || doPop);

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == PW'(RD_BUF_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_BUF_DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= 2'd0;
    end else begin
      if (doPush) begin
        data_q[wrPtr_q] <= pushData_i;
        tag_q[wrPtr_q]  <= pushTag_i;
        wrPtr_q         <= nextPtr(wrPtr_q);
      end
      if (doPop) begin
        rdPtr_q <= nextPtr(rdPtr_q);
      end
      if (doPush && !doPop) begin
        count_q <= count_q + 1'b1;
      end else if (!doPush && doPop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign count_o    = count_q;
  assign headData_o = data_q[rdPtr_q];
  assign headTag_o  = tag_q[rdPtr_q];

endmodule

// File: rtl/mat_rd_stream.sv
// Read-side master that walks a rows x cols matrix in RAM and streams it out.
// Define MAT_RD_TRANSPOSE_EN to add the 'transpose' port (column-major walk).
module mat_rd_stream
  import mat_pkg::*;
#(
  parameter int DATA = 16,
  parameter int ADDR = 5,
  parameter int DIM  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ADDR-1:0] base,
  input  logic [DIM-1:0]  rows_m1,
  input  logic [DIM-1:0]  cols_m1,
`ifdef MAT_RD_TRANSPOSE_EN
  input  logic            transpose,
`endif
  output logic            busy,
  output logic            done,
  output logic [ADDR-1:0] ram_addr,
  output logic            ram_we,
  output logic [DATA-1:0] ram_din,
  input  logic [DATA-1:0] ram_dout,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DATA-1:0] m_data,
  output logic            m_eor,
  output logic            m_last
);

  rd_state_e       state_q;
  logic [ADDR-1:0] addr_q;
  logic [DIM-1:0]  inner_q, outer_q, innerMax_q, outerMax_q;
  logic            busy_q, done_q, inflight_q;
  rd_tag_t         inflightTag_q;
`ifdef MAT_RD_TRANSPOSE_EN
  logic [ADDR-1:0] lineBase_q, lineStep_q, innerStep_q;
`endif

  logic [1:0]      bufCount;
  logic [DATA-1:0] headData;
  rd_tag_t         headTag;
  logic            pop, issue, innerEnd, lastElem;
  logic [2:0]      creditUse;
  rd_tag_t         issueTag;

  assign m_valid = (bufCount != 2'd0);
  assign pop     = m_valid && m_ready;

  // Slots committed after this edge: a pop frees one, the returning read takes one.
  assign creditUse = {1'b0, bufCount} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == ISSUE) && (creditUse < 3'(RD_BUF_DEPTH));

  assign innerEnd = (inner_q == innerMax_q);
  assign lastElem = innerEnd && (outer_q == outerMax_q);
  assign issueTag = '{eor: innerEnd, last: lastElem};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      inner_q       <= '0;
      outer_q       <= '0;
      innerMax_q    <= '0;
      outerMax_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      inflight_q    <= 1'b0;
      inflightTag_q <= '0;
`ifdef MAT_RD_TRANSPOSE_EN
      lineBase_q    <= '0;
      lineStep_q    <= '0;
      innerStep_q   <= '0;
`endif
    end else begin
      done_q        <= 1'b0;
      inflight_q    <= issue;
      inflightTag_q <= issueTag;
      case (state_q)
        IDLE: begin
          if (start && !done_q) begin
            addr_q  <= base;
            inner_q <= '0;
            outer_q <= '0;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
`ifdef MAT_RD_TRANSPOSE_EN
            lineBase_q <= base;
            if (transpose) begin
              innerMax_q  <= rows_m1;
              outerMax_q  <= cols_m1;
              innerStep_q <= ADDR'(cols_m1) + ADDR'(1);
              lineStep_q  <= ADDR'(1);
            end else begin
              innerMax_q  <= cols_m1;
              outerMax_q  <= rows_m1;
              innerStep_q <= ADDR'(1);
              lineStep_q  <= ADDR'(cols_m1) + ADDR'(1);
            end
`else
            innerMax_q <= cols_m1;
            outerMax_q <= rows_m1;
`endif
          end
        end
        ISSUE: begin
          if (issue) begin
            if (innerEnd) begin
              inner_q <= '0;
              outer_q <= outer_q + 1'b1;
            end else begin
              inner_q <= inner_q + 1'b1;
            end
`ifdef MAT_RD_TRANSPOSE_EN
            if (innerEnd) begin
              addr_q     <= lineBase_q + lineStep_q;
              lineBase_q <= lineBase_q + lineStep_q;
            end else begin
              addr_q <= addr_q + innerStep_q;
            end
`else
            // Row-major: the next row's base is always the current address plus one.
            addr_q <= addr_q + ADDR'(1);
`endif
            if (lastElem) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && headTag.last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mat_rd_buf #(.DATA(DATA)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inflight_q),
    .pushData_i (ram_dout),
    .pushTag_i  (inflightTag_q),
    .pop_i      (pop),
    .count_o    (bufCount),
    .headData_o (headData),
    .headTag_o  (headTag)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign ram_addr = addr_q;
  assign ram_we   = 1'b0;
  assign ram_din  = '0;
  assign m_data   = headData;
  assign m_eor    = headTag.eor;
  assign m_last   = headTag.last;

endmodule

// File: tb/tb_mat_rd_stream.sv
// Scoreboard bench for mat_rd_stream: directed matrices queue their expected
// elements, a negedge monitor pops and compares on every handshake.
module tb_mat_rd_stream;

  localparam int DATA = 16;
  localparam int ADDR = 5;
  localparam int DIM  = 3;

  logic            clk = 1'b0;
  logic            rst, start;
  logic [ADDR-1:0] base;
  logic [DIM-1:0]  rows_m1, cols_m1;
`ifdef MAT_RD_TRANSPOSE_EN
  logic            transpose;
`endif
  logic            busy, done, ram_we;
  logic [ADDR-1:0] ram_addr;
  logic [DATA-1:0] ram_din, ram_dout;
  logic            m_valid, m_ready, m_eor, m_last;
  logic [DATA-1:0] m_data;

  typedef struct packed {
    logic [15:0] data;
    logic        eor;
    logic        last;
  } exp_t;

  exp_t        expQ[$];
  int          total = 0;
  int          bad = 0;
  int          readyMode = 0;
  int          phase = 0;
  logic [3:0]  readyPat = 4'b1001;
  logic [15:0] mem [32];

  always #5 clk = ~clk;

  mat_rd_stream #(.DATA(DATA), .ADDR(ADDR), .DIM(DIM)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .rows_m1  (rows_m1),
    .cols_m1  (cols_m1),
`ifdef MAT_RD_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .busy     (busy),
    .done     (done),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_eor    (m_eor),
    .m_last   (m_last)
  );

  // RAM port model: word i holds 16'h5A00 + i, one-cycle registered read.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h5A00 + 16'(i);
  end

  always @(posedge clk) ram_dout <= mem[ram_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expectElem(input logic [15:0] d, input logic eor, input logic last);
    expQ.push_back('{data: d, eor: eor, last: last});
  endtask

  // Pulses start for one cycle; returns #1 into cycle 1 of the transfer.
  task automatic applyStimulus(input logic [ADDR-1:0] b, input logic [DIM-1:0] r, input logic [DIM-1:0] c);
    @(posedge clk); #1;
    start = 1'b1; base = b; rows_m1 = r; cols_m1 = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  // Downstream ready driver: 0 = always ready, 1 = pattern 1,0,0,1, else stalled.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        0: m_ready = 1'b1;
        1: begin
          m_ready = readyPat[phase[1:0]];
          phase   = (phase + 1) % 4;
        end
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops, hold-while-stalled, done exactly one cycle after m_last.
  initial begin
    logic        prevValid = 1'b0;
    logic        prevReady = 1'b0;
    logic        prevLastHs = 1'b0;
    logic        hsLast;
    logic [15:0] prevData = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevValid  = 1'b0;
        prevReady  = 1'b0;
        prevLastHs = 1'b0;
      end else begin
        if (prevValid && !prevReady) begin
          checkOutput("stallValid", 32'(m_valid), 32'd1);
          checkOutput("stallData", 32'(m_data), 32'(prevData));
        end
        hsLast = 1'b0;
        if (m_valid && m_ready) begin
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpectedElem: got %0h expected none", m_data);
          end else begin
            e = expQ.pop_front();
            checkOutput("mData", 32'(m_data), 32'(e.data));
            checkOutput("mEor", 32'(m_eor), 32'(e.eor));
            checkOutput("mLast", 32'(m_last), 32'(e.last));
            hsLast = m_last;
          end
        end
        if (done || prevLastHs) begin
          checkOutput("donePulse", 32'(done), 32'(prevLastHs));
          if (done) checkOutput("busyAtDone", 32'(busy), 32'd0);
        end
        prevValid  = m_valid;
        prevReady  = m_ready;
        prevData   = m_data;
        prevLastHs = hsLast;
      end
    end
  end

  initial begin
`ifdef MAT_RD_TRANSPOSE_EN
    logic [4:0] tAddr [6];
`endif
    rst = 1'b1; start = 1'b0; base = '0; rows_m1 = '0; cols_m1 = '0;
`ifdef MAT_RD_TRANSPOSE_EN
    transpose = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstValid", 32'(m_valid), 32'd0);
    checkOutput("rstEor", 32'(m_eor), 32'd0);
    checkOutput("rstLast", 32'(m_last), 32'd0);
    checkOutput("rstAddr", 32'(ram_addr), 32'd0);
    checkOutput("rstData", 32'(m_data), 32'd0);
    checkOutput("ramWe", 32'(ram_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 2x3 at base 4, always ready
    $display("[TB] 2x3 at base 4");
    expectElem(16'h5A04, 1'b0, 1'b0);
    expectElem(16'h5A05, 1'b0, 1'b0);
    expectElem(16'h5A06, 1'b1, 1'b0);
    expectElem(16'h5A07, 1'b0, 1'b0);
    expectElem(16'h5A08, 1'b0, 1'b0);
    expectElem(16'h5A09, 1'b1, 1'b1);
    applyStimulus(5'd4, 3'd1, 3'd2);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("t1Addr", 32'(ram_addr), 32'(4 + k));
      checkOutput("t1Valid", 32'(m_valid), (k >= 2) ? 32'd1 : 32'd0);
      if (k == 0) checkOutput("t1Busy", 32'(busy), 32'd1);
    end
    waitDone(20, "t1Done");
    @(negedge clk);
    checkOutput("t1BusyAfter", 32'(busy), 32'd0);
    checkOutput("t1Drained", 32'(expQ.size()), 32'd0);

    // 1x1 at base 31, plus a start landing in the done cycle
    $display("[TB] 1x1 at base 31");
    expectElem(16'h5A1F, 1'b1, 1'b1);
    applyStimulus(5'd31, 3'd0, 3'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; base = 5'd0;
    @(negedge clk);
    checkOutput("t2Done", 32'(done), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("t2BusyAfter", 32'(busy), 32'd0);
    checkOutput("t2NoRestart", 32'(m_valid), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("t2StillIdle", 32'(m_valid), 32'd0);

    // 3x4 at base 28 wraps past the top of memory
    $display("[TB] 3x4 at base 28");
    expectElem(16'h5A1C, 1'b0, 1'b0);
    expectElem(16'h5A1D, 1'b0, 1'b0);
    expectElem(16'h5A1E, 1'b0, 1'b0);
    expectElem(16'h5A1F, 1'b1, 1'b0);
    expectElem(16'h5A00, 1'b0, 1'b0);
    expectElem(16'h5A01, 1'b0, 1'b0);
    expectElem(16'h5A02, 1'b0, 1'b0);
    expectElem(16'h5A03, 1'b1, 1'b0);
    expectElem(16'h5A04, 1'b0, 1'b0);
    expectElem(16'h5A05, 1'b0, 1'b0);
    expectElem(16'h5A06, 1'b0, 1'b0);
    expectElem(16'h5A07, 1'b1, 1'b1);
    applyStimulus(5'd28, 3'd2, 3'd3);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checkOutput("t3Addr", 32'(ram_addr), 32'((28 + k) % 32));
    end
    waitDone(20, "t3Done");
    checkOutput("t3Drained", 32'(expQ.size()), 32'd0);

    // 2x2 at base 0 with ready toggling 1,0,0,1
    $display("[TB] 2x2 with backpressure");
    phase = 0;
    readyMode = 1;
    expectElem(16'h5A00, 1'b0, 1'b0);
    expectElem(16'h5A01, 1'b1, 1'b0);
    expectElem(16'h5A02, 1'b0, 1'b0);
    expectElem(16'h5A03, 1'b1, 1'b1);
    applyStimulus(5'd0, 3'd1, 3'd1);
    waitDone(60, "t4Done");
    readyMode = 0;
    checkOutput("t4Drained", 32'(expQ.size()), 32'd0);

    // 2x2 at base 8 with stray starts in cycles 2 and 5
    $display("[TB] 2x2 with ignored starts");
    expectElem(16'h5A08, 1'b0, 1'b0);
    expectElem(16'h5A09, 1'b1, 1'b0);
    expectElem(16'h5A0A, 1'b0, 1'b0);
    expectElem(16'h5A0B, 1'b1, 1'b1);
    applyStimulus(5'd8, 3'd1, 3'd1);
    @(posedge clk); #1;
    start = 1'b1; base = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(20, "t5Done");
    repeat (6) @(negedge clk);
    checkOutput("t5Idle", 32'(busy), 32'd0);
    checkOutput("t5NoValid", 32'(m_valid), 32'd0);
    checkOutput("t5Drained", 32'(expQ.size()), 32'd0);

    // reset in cycle 3 of a stalled 2x2 aborts without done
    $display("[TB] reset abort");
    readyMode = 2;
    applyStimulus(5'd0, 3'd1, 3'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6ValidBefore", 32'(m_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6Valid", 32'(m_valid), 32'd0);
    checkOutput("t6Busy", 32'(busy), 32'd0);
    checkOutput("t6Done", 32'(done), 32'd0);
    readyMode = 0;
    repeat (5) @(negedge clk);
    checkOutput("t6StillIdle", 32'(busy), 32'd0);

`ifdef MAT_RD_TRANSPOSE_EN
    // column-major 2x3 at base 0
    $display("[TB] transpose 2x3");
    tAddr = '{5'd0, 5'd3, 5'd1, 5'd4, 5'd2, 5'd5};
    transpose = 1'b1;
    expectElem(16'h5A00, 1'b0, 1'b0);
    expectElem(16'h5A03, 1'b1, 1'b0);
    expectElem(16'h5A01, 1'b0, 1'b0);
    expectElem(16'h5A04, 1'b1, 1'b0);
    expectElem(16'h5A02, 1'b0, 1'b0);
    expectElem(16'h5A05, 1'b1, 1'b1);
    applyStimulus(5'd0, 3'd1, 3'd2);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("tpAddr", 32'(ram_addr), 32'(tAddr[k]));
    end
    waitDone(20, "tpDone");
    transpose = 1'b0;
    checkOutput("tpDrained", 32'(expQ.size()), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mat_rd_stream.md
Name: mat_rd_stream

Overview:
- Read-side master for one port of the team's dual-port matrix RAM (1-cycle registered read latency, per-port write enable).
- On a start pulse it walks a rows x cols matrix stored row-major at a base address.
- Issues one RAM read per cycle and streams elements out on a valid/ready interface with end-of-row and end-of-matrix flags.
- Sits between matrix storage and downstream compute (multiplier/adder pipelines).

Parameters:
- DATA, 16, element width; equals the RAM data width.
- ADDR, 5, RAM address width; matrix storage is 2**ADDR words.
- DIM, 3, width of the row/column count fields; max matrix is 2**DIM x 2**DIM.

Ports:
- clk  in  1  single clock for all logic and the RAM port.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- base  in  ADDR  address of element (0,0); sampled on accepted start.
- rows_m1  in  DIM  row count minus 1; sampled on accepted start.
- cols_m1  in  DIM  column count minus 1; sampled on accepted start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last element handshakes.
- ram_addr  out  ADDR  RAM port address.
- ram_we  out  1  tied 0; read-only master.
- ram_din  out  DATA  tied 0.
- ram_dout  in  DATA  RAM read data, valid the cycle after ram_addr is presented.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA  element.
- m_eor  out  1  element is the last of its row.
- m_last  out  1  element is the last of the matrix.

Behaviour:
- Reset: state IDLE; busy, done, m_valid, m_eor, m_last = 0; ram_addr, m_data = 0; buffer and in-flight credit cleared. Reset during any state aborts immediately; no done pulse.
- FSM IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE: on start=1, latch base, rows_m1, cols_m1 and clear counters r=c=0; go to ISSUE.
- ISSUE: present ram_addr = row_base + c, where row_base starts at base and adds (cols_m1+1) at each row end. All address arithmetic is modulo 2**ADDR, so wrap past the top of memory is legal and silent.
  - A read issues in a cycle only if buffer occupancy + in-flight reads < 2. This credit rule is required; m_ready must never cause data loss.
  - Each issue tags the read with eor = (c==cols_m1) and last = eor && (r==rows_m1).
  - After the last read issues, go to DRAIN.
- Returning data: ram_dout is written into a 2-entry FIFO the cycle after its issue, with its tags.
- Output side: m_valid = FIFO non-empty; m_data/m_eor/m_last come from the FIFO head.
  - Pop on m_valid && m_ready.
  - m_data and flags are held stable while m_valid && !m_ready.
- DRAIN: when the element with m_last handshakes, pulse done=1 in the following cycle, deassert busy in that same cycle, and return to IDLE.
- Latency: start accepted in cycle 0, first address in cycle 1, first m_valid in cycle 3.
- Throughput: with m_ready held high, sustained 1 element/cycle; done lands 1 cycle after the final handshake.
- start while busy is ignored and not queued. start in the same cycle as done is ignored.
- 1x1 matrix (rows_m1=cols_m1=0): a single element with m_eor=m_last=1.
- m_ready low for an arbitrary time: issue stalls at 2 outstanding/buffered; nothing is dropped or duplicated.

Optional Feature:
- Macro MAT_RD_TRANSPOSE_EN.
- When defined: adds input port transpose (1 bit, sampled on start).
  - transpose=1 gives column-major traversal: c is the outer loop, r the inner; address = base + r*(cols_m1+1) + c, computed incrementally.
  - m_eor then marks the end of each column; m_last is unchanged in meaning.
- When undefined: the port is absent and traversal is row-major only. No logic for the column stepper is generated.

Decomposition:
- Shared package mat_pkg holds:
  - the FSM state enum (IDLE, ISSUE, DRAIN);
  - localparam RD_BUF_DEPTH = 2;
  - the element tag type {eor, last}.
- One sub-module, mat_rd_buf: a 2-entry FIFO of {data, eor, last} with push/pop/count, where pop has priority semantics for simultaneous push and pop.

Test Plan:
- 2x3 at base 4, m_ready=1 -> addresses 4,5,6,7,8,9 in cycles 1-6; m_eor on elements 3 and 6; m_last on element 6; done in the cycle after it.
- 1x1 at base 31 -> one element, data=mem[31], m_eor=m_last=1, done pulse, busy low afterward.
- 3x4 at base 28 -> addresses wrap 28,29,30,31,0,1,...,7; data matches the RAM preload.
- 2x2 at base 0 with m_ready toggling 1,0,0,1,... -> exactly 4 handshakes in order mem[0..3]; never more than 2 reads outstanding; m_data stable while stalled.
- start pulsed again in cycles 2 and 5 of an active 2x2 -> ignored; exactly one done. Reset asserted in cycle 3 -> m_valid=0 and busy=0 next cycle; no done.
- With MAT_RD_TRANSPOSE_EN, 2x3 at base 0, transpose=1 -> addresses 0,3,1,4,2,5; m_eor on elements 2, 4 and 6.
